// File: rtl/semi_turn_executor.sv
// Timed executor for one semi-auto direction decision: turn (or U-turn), then
// forward escape travel, ending with a done pulse (blocked on front-obstacle abort).
module semi_turn_executor #(
   parameter int unsigned TURN_CYCLES   = 50_000_000,
   parameter int unsigned BACK_CYCLES   = 100_000_000,
   parameter int unsigned ESCAPE_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [1:0] cmd,
   output logic       cmd_ready,
   input  logic       front_detector,
   output logic       move_forward,
   output logic       turn_left,
   output logic       turn_right,
   output logic       done,
   output logic       blocked
);

   localparam int unsigned CNT_W = 32;

   localparam logic [1:0] CMD_FWD   = 2'b00;
   localparam logic [1:0] CMD_LEFT  = 2'b01;
   localparam logic [1:0] CMD_RIGHT = 2'b10;
   localparam logic [1:0] CMD_BACK  = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TURN   = 2'd1,
      ESCAPE = 2'd2
   } state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [1:0]         cmd_q, cmd_d;
   logic               ready_d, fwd_d, left_d, right_d, done_d, blocked_d;

   // State, counter, latched command and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         cmd_q        <= CMD_FWD;
         cmd_ready    <= 1'b1;
         move_forward <= 1'b0;
         turn_left    <= 1'b0;
         turn_right   <= 1'b0;
         done         <= 1'b0;
         blocked      <= 1'b0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         cmd_q        <= cmd_d;
         cmd_ready    <= ready_d;
         move_forward <= fwd_d;
         turn_left    <= left_d;
         turn_right   <= right_d;
         done         <= done_d;
         blocked      <= blocked_d;
      end
   end

   // Next state and next-cycle output values
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      cmd_d     = cmd_q;
      fwd_d     = 1'b0;
      left_d    = 1'b0;
      right_d   = 1'b0;
      done_d    = 1'b0;
      blocked_d = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               cmd_d = cmd;
               case (cmd)
                  CMD_LEFT: begin
                     state_d = TURN;
                     cnt_d   = CNT_W'(TURN_CYCLES);
                     left_d  = 1'b1;
                  end
                  CMD_RIGHT: begin
                     state_d = TURN;
                     cnt_d   = CNT_W'(TURN_CYCLES);
                     right_d = 1'b1;
                  end
                  CMD_BACK: begin
                     state_d = TURN;
                     cnt_d   = CNT_W'(BACK_CYCLES);
                     right_d = 1'b1;
                  end
                  default: begin
                     if (front_detector) begin
                        done_d    = 1'b1;
                        blocked_d = 1'b1;
                     end else begin
                        state_d = ESCAPE;
                        cnt_d   = CNT_W'(ESCAPE_CYCLES);
                        fwd_d   = 1'b1;
                     end
                  end
               endcase
            end
         end
         TURN: begin
            cnt_d = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_d = ESCAPE;
               cnt_d   = CNT_W'(ESCAPE_CYCLES);
               fwd_d   = 1'b1;
            end else begin
               left_d  = (cmd_q == CMD_LEFT);
               right_d = (cmd_q != CMD_LEFT);
            end
         end
         ESCAPE: begin
            cnt_d = cnt - CNT_W'(1);
            // Obstacle wins over normal completion in the final cycle
            if (front_detector) begin
               state_d   = IDLE;
               done_d    = 1'b1;
               blocked_d = 1'b1;
            end else if (cnt == CNT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               fwd_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
   end

endmodule

// File: doc/semi_turn_executor.md
# semi_turn_executor

Executes one direction decision of the semi-automatic driving mode, sitting directly downstream of `semi_state`. It accepts a 2-bit direction command, such as the `cur` output of `semi_state`, through a valid/ready handshake. It then drives the motion outputs through a timed sequence: turn (or U-turn) for a fixed number of cycles, then forward "escape" travel so the car clears the intersection before `semi_state` evaluates detectors again. It reports completion, or a front-obstacle abort, with a one-cycle `done` pulse.

## Interface
- `TURN_CYCLES`, default 50_000_000: cycles of `turn_left`/`turn_right` for a 90° turn; legal range 1 to 2^32−1.
- `BACK_CYCLES`, default 100_000_000: cycles of `turn_right` for a 180° U-turn; legal range 1 to 2^32−1.
- `ESCAPE_CYCLES`, default 25_000_000: cycles of `move_forward` after any command; legal range 1 to 2^32−1.
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd`  in  2  direction: 00 forward, 01 left, 10 right, 11 back.
- `cmd_ready`  out  1  high only in IDLE.
- `front_detector`  in  1  1 = obstacle ahead.
- `move_forward`  out  1  forward motor command.
- `turn_left`  out  1  left rotate command.
- `turn_right`  out  1  right rotate command.
- `done`  out  1  one-cycle pulse when a sequence ends.
- `blocked`  out  1  qualifies `done`: the sequence ended by obstacle.

## Operation
- States: IDLE, TURN, ESCAPE. A 32-bit down-counter `cnt` is shared by TURN and ESCAPE.
- Reset values: state IDLE, `cnt`=0. Outputs: `cmd_ready`=1, all motion outputs 0, `done`=0, `blocked`=0. Reset takes effect immediately, including mid-sequence; motion outputs drop asynchronously.
- IDLE: a command is accepted when `cmd_valid && cmd_ready`; `cmd` is latched.
  - 01 → TURN, `cnt`=TURN_CYCLES, drive `turn_left`.
  - 10 → TURN, `cnt`=TURN_CYCLES, drive `turn_right`.
  - 11 → TURN, `cnt`=BACK_CYCLES, drive `turn_right` (U-turn is clockwise).
  - 00 with `front_detector`=0 → ESCAPE, `cnt`=ESCAPE_CYCLES.
  - 00 with `front_detector`=1 → rejected: stay IDLE, pulse `done` with `blocked`=1. No motion output asserts.
- TURN: decrement `cnt` each cycle. In the last turn cycle (`cnt`=1), load `cnt`=ESCAPE_CYCLES and go to ESCAPE. `front_detector` is ignored in TURN.
- ESCAPE: `move_forward`=1 and `cnt` decrements each cycle.
  - If `front_detector`=1 in any ESCAPE cycle, go to IDLE next cycle with `done`=1, `blocked`=1.
  - Otherwise, when `cnt`=1, go to IDLE with `done`=1, `blocked`=0.
- Motion outputs are registered and mutually exclusive; at most one is high in any cycle. All are 0 in IDLE.
- `cmd` changes while not ready are ignored. The latched command is held until the sequence ends.
- `blocked` is valid only while `done`=1; it is 0 otherwise.

## Timing
- All outputs are registered. The acceptance edge is edge 0. Turn output is high for cycles 1..N, where N = TURN_CYCLES or BACK_CYCLES. `move_forward` is high for cycles N+1..N+ESCAPE_CYCLES.
- `done` is high for exactly one cycle: cycle N+ESCAPE_CYCLES+1. In that same cycle `cmd_ready`=1, and a valid command there is accepted, giving zero-bubble back-to-back sequences.
- Forward command: `move_forward` is high for cycles 1..ESCAPE_CYCLES, and `done` is at cycle ESCAPE_CYCLES+1.
- Obstacle abort: `front_detector` is sampled high at edge k inside ESCAPE. `move_forward`=0 and `done`=`blocked`=1 in cycle k+1.
- Rejected forward: `done`=`blocked`=1 in cycle 1, and `cmd_ready` stays 1 throughout.
- Abort coinciding with the final ESCAPE cycle reports `blocked`=1.

## Test plan
- Use TURN=4, BACK=8, ESCAPE=3. Left command accepted at cycle 0:
  - `turn_left` is high for cycles 1–4 and `move_forward` for cycles 5–7.
  - `done`=1, `blocked`=0 at cycle 8.
  - `cmd_ready` is 0 for cycles 1–7.
- Back command: `turn_right` is high for 8 cycles, then `move_forward` for 3. `turn_left` never asserts. `done` is at cycle 12.
- Forward command with `front_detector`=1 at acceptance: no motion output; `done`=`blocked`=1 at cycle 1.
- Right command with `front_detector` pulsed high at cycle 6 (ESCAPE): `move_forward` is 0 from cycle 7, with `done`=`blocked`=1 at cycle 7. A pulse during cycles 1–4 (TURN) has no effect.
- Back-to-back: `cmd_valid` held high with left then forward. The second command is accepted in the `done` cycle (8), and `move_forward` is high for cycles 9–11.
- `rst_n` asserted at cycle 3 of a turn: all outputs drop immediately and `cmd_ready`=1. After release, a new command runs its full length.
